display_capture: RTL and testbench

Receive-side counterpart of the multiplexed seven-segment display driver. It samples the active-low digit-select bus and the segment bus, and filters out transients with a stability check. Each stable segment pattern is decoded back to a hex nibble and stored per digit. Once all eight digits are captured, the block publishes the reconstructed 32-bit value with a one-cycle strobe. It sits on the display pins (loopback or board-level monitor) to check display output in simulation and on hardware.

---
 rtl/display_pkg.sv | 50 +++++
 rtl/seg_decode.sv | 24 ++
 rtl/display_capture.sv | 139 +++++++++++++
 tb/tb_display_capture.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: constants shared by the seven-segment display driver and its
// consumers. Segment bytes are bit7=a ... bit1=g, bit0=dp, active-high, with
// dp shown as 0. Provides the nibble-to-pattern table, digit count, idle
// select value and small select-bus helpers.
package display_pkg;

  typedef logic [7:0] seg_t;
  typedef logic [3:0] nibble_t;

  localparam int unsigned NUM_DIGITS = 8;
  localparam logic [7:0]  SEL_IDLE   = 8'hFF;

  localparam seg_t SEG_0 = 8'hFC;
  localparam seg_t SEG_1 = 8'h60;
  localparam seg_t SEG_2 = 8'hDA;
  localparam seg_t SEG_3 = 8'hF2;
  localparam seg_t SEG_4 = 8'h66;
  localparam seg_t SEG_5 = 8'hB6;
  localparam seg_t SEG_6 = 8'hBE;
  localparam seg_t SEG_7 = 8'hE0;
  localparam seg_t SEG_8 = 8'hFE;
  localparam seg_t SEG_9 = 8'hF6;
  localparam seg_t SEG_A = 8'hEE;
  localparam seg_t SEG_B = 8'h3E;
  localparam seg_t SEG_C = 8'h1A;
  localparam seg_t SEG_D = 8'h7A;
  localparam seg_t SEG_E = 8'h9E;
  localparam seg_t SEG_F = 8'h8E;

  localparam seg_t SEG_TABLE [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
  };

  // Active-low select is legal when exactly one bit is low.
  function automatic logic sel_is_legal(input logic [7:0] sel);
    return $onehot(~sel);
  endfunction

  // Index of the lowest low bit of an active-low select bus.
  function automatic logic [2:0] sel_index(input logic [7:0] sel);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = NUM_DIGITS; i > 0; i--) begin
      if (!sel[i-1]) idx = 3'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// seg_decode: combinational seven-segment decoder.
//   seg    in  7  segments a..g (bit6=a ... bit0=g); dp is not presented
//   nibble out 4  decoded hex value (0 when invalid)
//   valid  out 1  pattern matches one of the 16 hex glyphs
module seg_decode
  import display_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       valid
);

  always_comb begin
    nibble = '0;
    valid  = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i][7:1]) begin
        nibble = 4'(i);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_capture.sv
// display_capture: reconstructs the 32-bit value shown on a multiplexed
// seven-segment display from its select and segment pins.
//   STABLE       param  identical samples needed to accept a digit (1..15)
//   clock        in  1  system clock, posedge
//   rst_n        in  1  asynchronous active-low reset
//   selecter_in  in  8  active-low one-hot digit select, 8'hFF idle
//   seg_in       in  8  segment pattern a..g,dp (active-high)
//   err_clr      in  1  synchronous clear of the sticky error flags
//   frame_data   out 32 last complete frame, digit i at [4i+3:4i]
//   frame_valid  out 1  one-cycle pulse when frame_data updates
//   digit_seen   out 8  digits accepted since the last frame completed
//   err_seg      out 1  sticky: undecodable pattern under a legal select
//   err_sel      out 1  sticky: two or more select bits low
module display_capture
  import display_pkg::*;
#(
  parameter int unsigned STABLE = 2
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [7:0]  selecter_in,
  input  logic [7:0]  seg_in,
  input  logic        err_clr,
  output logic [31:0] frame_data,
  output logic        frame_valid,
  output logic [7:0]  digit_seen,
  output logic        err_seg,
  output logic        err_sel
);

  localparam logic [3:0] STABLE_CNT = 4'(STABLE);

  logic [7:0] sel_q;
  logic [7:0] seg_q;
  logic [3:0] run_cnt;
  logic [3:0] run_cnt_next;
  logic       same;
  logic       reach;
  logic       acc_q;

  logic [3:0] digit_q [NUM_DIGITS];

  logic       sel_legal;
  logic       sel_idle;
  logic [2:0] sel_idx;
  logic [3:0] dec_nibble;
  logic       dec_valid;

  logic       wr_digit;
  logic       set_err_seg;
  logic       set_err_sel;
  logic [7:0] seen_next;
  logic       frame_done;
  logic [31:0] frame_next;

  // Run tracking against the incoming sample. The accept flag is registered
  // so it lines up with the sample stage that produced it; a saturated run
  // does not re-fire.
  always_comb begin
    same         = (selecter_in == sel_q) && (seg_in == seg_q);
    run_cnt_next = 4'd1;
    if (same) begin
      run_cnt_next = (run_cnt == STABLE_CNT) ? run_cnt : run_cnt + 4'd1;
    end
    reach = (run_cnt_next == STABLE_CNT) && !(same && run_cnt == STABLE_CNT);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      seg_q   <= '0;
      run_cnt <= '0;
      acc_q   <= 1'b0;
    end else begin
      sel_q   <= selecter_in;
      seg_q   <= seg_in;
      run_cnt <= run_cnt_next;
      acc_q   <= reach;
    end
  end

  seg_decode u_seg_decode (
    .seg    (seg_q[7:1]),
    .nibble (dec_nibble),
    .valid  (dec_valid)
  );

  always_comb begin
    sel_legal   = sel_is_legal(sel_q);
    sel_idle    = (sel_q == SEL_IDLE);
    sel_idx     = sel_index(sel_q);
    wr_digit    = acc_q && sel_legal && dec_valid;
    set_err_seg = acc_q && sel_legal && !dec_valid;
    set_err_sel = acc_q && !sel_legal && !sel_idle;
    seen_next   = digit_seen;
    if (wr_digit) seen_next[sel_idx] = 1'b1;
    frame_done  = wr_digit && (seen_next == '1);
  end

  // Frame image including the nibble being written on this edge.
  always_comb begin
    frame_next = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      frame_next[4*i +: 4] = (wr_digit && sel_idx == 3'(i)) ? dec_nibble : digit_q[i];
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
      digit_seen  <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (wr_digit) digit_q[sel_idx] <= dec_nibble;
      if (frame_done) begin
        frame_data  <= frame_next;
        frame_valid <= 1'b1;
        digit_seen  <= '0;
      end else begin
        digit_seen  <= seen_next;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      err_seg <= 1'b0;
      err_sel <= 1'b0;
    end else begin
      if (set_err_seg)  err_seg <= 1'b1;
      else if (err_clr) err_seg <= 1'b0;
      if (set_err_sel)  err_sel <= 1'b1;
      else if (err_clr) err_sel <= 1'b0;
    end
  end

endmodule

// File: tb/tb_display_capture.sv
// tb_display_capture: scoreboard bench for display_capture with STABLE=2.
// Expected frames are queued as digits are driven and compared when
// frame_valid pulses.
module tb_display_capture;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  selecter_in = 8'hFF;
  logic [7:0]  seg_in = 8'h00;
  logic        err_clr = 1'b0;
  logic [31:0] frame_data;
  logic        frame_valid;
  logic [7:0]  digit_seen;
  logic        err_seg;
  logic        err_sel;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned frames = 0;
  logic [31:0] exp_q [$];

  logic [7:0] glyph [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'h9E, 8'h8E
  };

  display_capture #(.STABLE(2)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .selecter_in (selecter_in),
    .seg_in      (seg_in),
    .err_clr     (err_clr),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .digit_seen  (digit_seen),
    .err_seg     (err_seg),
    .err_sel     (err_sel)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; holds the pattern for the given number of cycles.
  task automatic drive(input logic [7:0] sel, input logic [7:0] seg, input int cycles);
    selecter_in = sel;
    seg_in      = seg;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic put_digit(input int idx, input int val);
    logic [7:0] sel;
    sel = ~(8'h01 << idx);
    drive(sel, glyph[val], 4);
  endtask

  always @(negedge clock) begin
    if (frame_valid) begin
      frames++;
      if (exp_q.size() == 0) check("frame_unexpected", 32'd1, 32'd0);
      else check("frame_data", frame_data, exp_q.pop_front());
    end
  end

  initial begin
    repeat (3) @(negedge clock);
    check("rst_frame_data", frame_data, 32'h0);
    check("rst_frame_valid", {31'h0, frame_valid}, 32'h0);
    check("rst_digit_seen", {24'h0, digit_seen}, 32'h0);
    check("rst_errs", {30'h0, err_seg, err_sel}, 32'h0);
    rst_n = 1'b1;
    drive(8'hFF, 8'h00, 3);

    // Full frame 1,2,3,4,5,6,7,0.
    exp_q.push_back(32'h0765_4321);
    for (int i = 0; i < 8; i++) put_digit(i, (i + 1) % 8);
    drive(8'hFF, 8'h00, 3);
    check("t1_frames", frames, 1);
    check("t1_seen_clear", {24'h0, digit_seen}, 32'h0);

    // Single-cycle glitch must not be accepted.
    drive(8'hFE, 8'h60, 1);
    drive(8'hFF, 8'h00, 4);
    check("glitch_seen", {24'h0, digit_seen}, 32'h0);
    check("glitch_errs", {30'h0, err_seg, err_sel}, 32'h0);

    // Undecodable pattern on digit 2.
    drive(8'hFB, 8'h00, 4);
    drive(8'hFF, 8'h00, 2);
    check("segerr_flag", {31'h0, err_seg}, 32'h1);
    check("segerr_seen", {24'h0, digit_seen}, 32'h0);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    check("segerr_clr", {31'h0, err_seg}, 32'h0);

    // Two select bits low.
    drive(8'hFC, 8'hFC, 4);
    drive(8'hFF, 8'h00, 2);
    check("selerr_flag", {31'h0, err_sel}, 32'h1);
    check("selerr_seen", {24'h0, digit_seen}, 32'h0);
    check("selerr_no_seg", {31'h0, err_seg}, 32'h0);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    check("selerr_clr", {31'h0, err_sel}, 32'h0);

    // Accept latency, dp ignored, overwrite of digit 3.
    exp_q.push_back(32'hFEDC_9BA0);
    drive(8'hFE, 8'hFD, 2);
    check("latency_early", {24'h0, digit_seen}, 32'h0);
    drive(8'hFE, 8'hFD, 2);
    check("latency_hit", {24'h0, digit_seen}, 32'h01);
    put_digit(3, 5);
    check("ovr_seen_a", {24'h0, digit_seen}, 32'h09);
    put_digit(3, 9);
    check("ovr_seen_b", {24'h0, digit_seen}, 32'h09);
    put_digit(1, 10);
    put_digit(2, 11);
    put_digit(4, 12);
    put_digit(5, 13);
    put_digit(6, 14);
    put_digit(7, 15);
    drive(8'hFF, 8'h00, 3);
    check("ovr_frames", frames, 2);

    // Reset mid-frame discards partial capture.
    for (int i = 0; i < 5; i++) put_digit(i, 3);
    drive(8'hFF, 8'h00, 1);
    check("partial_seen", {24'h0, digit_seen}, 32'h1F);
    rst_n = 1'b0;
    #1;
    check("mid_rst_frame_data", frame_data, 32'h0);
    check("mid_rst_seen", {24'h0, digit_seen}, 32'h0);
    @(negedge clock);
    rst_n = 1'b1;
    drive(8'hFF, 8'h00, 3);
    check("mid_rst_frames", frames, 2);
    exp_q.push_back(32'hFEDC_BA98);
    for (int i = 0; i < 8; i++) put_digit(i, 8 + i);
    drive(8'hFF, 8'h00, 3);
    check("fresh_frames", frames, 3);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
